// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Latency: n/a (types only). Backpressure: n/a.
package pipeline_hazard_pkg;

    localparam int PL_EX  = 1;
    localparam int PL_MEM = 2;
    localparam int PL_WB  = 3;

    // Entries store rd at a fixed maximum width so one struct serves every ADDR_WIDTH.
    localparam int MAX_ADDR_WIDTH = 8;

    typedef struct packed {
        logic                      valid;
        logic [MAX_ADDR_WIDTH-1:0] rd;
        logic                      write;
        logic                      is_load;
    } hazard_entry_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// ID-stage register fields in, stall and EX-stage forward selects out.
// Latency: stall combinational, ex_* registered. Backpressure: stall holds IF/ID upstream.
interface pipeline_hazard_unit_if #(
    parameter int READ_PORTS = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int SEL_W      = 2
);
    logic                             hold;
    logic                             flush;
    logic                             id_valid;
    logic [READ_PORTS*ADDR_WIDTH-1:0] id_rs_addr;
    logic [ADDR_WIDTH-1:0]            id_rd_addr;
    logic                             id_rd_write;
    logic                             id_is_load;
    logic                             stall;
    logic                             ex_valid;
    logic [READ_PORTS*SEL_W-1:0]      ex_fwd_sel;

    modport master (
        output hold, flush, id_valid, id_rs_addr, id_rd_addr, id_rd_write, id_is_load,
        input  stall, ex_valid, ex_fwd_sel
    );

    modport slave (
        input  hold, flush, id_valid, id_rs_addr, id_rd_addr, id_rd_write, id_is_load,
        output stall, ex_valid, ex_fwd_sel
    );

endinterface

// File: rtl/pipeline_hazard_unit_match.sv
// Priority search of in-flight entries for one source operand; youngest producer wins.
// Latency: purely combinational. Backpressure: none.
module hazard_match
    import pipeline_hazard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int SEL_W      = 2
) (
    input  hazard_entry_t          entries [1:DEPTH],
    input  logic [ADDR_WIDTH-1:0]  rs_addr,
    output logic                   hit,
    output logic [SEL_W-1:0]       k,
    output logic                   is_load
);

    logic [MAX_ADDR_WIDTH-1:0] rs_ext;
    assign rs_ext = MAX_ADDR_WIDTH'(rs_addr);

    // Scan oldest to youngest so the lowest matching index overrides the rest.
    always_comb begin
        hit     = 1'b0;
        k       = '0;
        is_load = 1'b0;
        for (int i = DEPTH; i >= 1; i--) begin
            if (entries[i].valid && entries[i].write &&
                entries[i].rd == rs_ext && rs_ext != '0) begin
                hit     = 1'b1;
                k       = SEL_W'(i);
                is_load = entries[i].is_load;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Tracks in-flight destinations, raises load-use stall and registers EX forward selects.
// Latency: stall 0 cycles (comb), ex_valid/ex_fwd_sel 1 cycle. Backpressure: hold freezes all state.
module pipeline_hazard_unit
    import pipeline_hazard_pkg::*;
#(
    parameter int READ_PORTS = 2,
    parameter int DEPTH      = 3,
    parameter int ADDR_WIDTH = 5,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = sel_width(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    pipeline_hazard_unit_if.slave   bus
);

    if (ADDR_WIDTH > MAX_ADDR_WIDTH) begin : g_bad_addr
        $error("ADDR_WIDTH exceeds MAX_ADDR_WIDTH");
    end
    if (LOAD_READY < 1 || LOAD_READY > DEPTH) begin : g_bad_ready
        $error("LOAD_READY must lie in 1..DEPTH");
    end

    hazard_entry_t               entries [1:DEPTH];
    hazard_entry_t               entry_in;
    logic [READ_PORTS-1:0]       hit;
    logic [READ_PORTS-1:0]       hit_load;
    logic [READ_PORTS-1:0]       load_use;
    logic [SEL_W-1:0]            hit_k [READ_PORTS];
    logic [READ_PORTS*SEL_W-1:0] fwd_sel_next;
    logic                        ex_valid_q;
    logic [READ_PORTS*SEL_W-1:0] ex_fwd_sel_q;
    logic                        stall;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        hazard_match #(
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .SEL_W      (SEL_W)
        ) u_match (
            .entries (entries),
            .rs_addr (bus.id_rs_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .hit     (hit[p]),
            .k       (hit_k[p]),
            .is_load (hit_load[p])
        );

        assign load_use[p] = hit[p] & hit_load[p] & (int'(hit_k[p]) < LOAD_READY);
    end

    assign stall = bus.id_valid & ~bus.flush & (|load_use);

    // Producer at stage k will sit one stage further on when the consumer reaches EX.
    // A producer leaving WB has already written the regfile, so it needs no bypass.
    always_comb begin
        fwd_sel_next = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (hit[p] && (int'(hit_k[p]) + 1 <= DEPTH)) begin
                fwd_sel_next[p*SEL_W +: SEL_W] = SEL_W'(int'(hit_k[p]) + 1);
            end
        end
    end

    always_comb begin
        entry_in = '0;
        if (!bus.flush && !stall) begin
            entry_in.valid   = bus.id_valid;
            entry_in.rd      = MAX_ADDR_WIDTH'(bus.id_rd_addr);
            entry_in.write   = bus.id_rd_write & bus.id_valid;
            entry_in.is_load = bus.id_is_load;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= DEPTH; i++) begin
                entries[i] <= '0;
            end
            ex_valid_q   <= 1'b0;
            ex_fwd_sel_q <= '0;
        end else if (!bus.hold) begin
            for (int i = DEPTH; i >= 2; i--) begin
                entries[i] <= entries[i-1];
            end
            entries[1] <= entry_in;
            if (bus.flush || stall) begin
                ex_valid_q   <= 1'b0;
                ex_fwd_sel_q <= '0;
            end else begin
                ex_valid_q   <= bus.id_valid;
                ex_fwd_sel_q <= fwd_sel_next;
            end
        end
    end

    assign bus.stall      = stall;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_fwd_sel = ex_fwd_sel_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed scoreboard bench for pipeline_hazard_unit (DEPTH=3, LOAD_READY=2, two read ports).
module tb_pipeline_hazard_unit;
    import pipeline_hazard_pkg::*;

    localparam int RP = 2;
    localparam int AW = 5;
    localparam int SW = sel_width(3);

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipeline_hazard_unit_if #(.READ_PORTS(RP), .ADDR_WIDTH(AW), .SEL_W(SW)) hif ();

    pipeline_hazard_unit #(
        .READ_PORTS (RP),
        .DEPTH      (3),
        .ADDR_WIDTH (AW),
        .LOAD_READY (2),
        .SEL_W      (SW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (hif.slave)
    );

    typedef struct {
        string      nm;
        logic       v;
        logic [3:0] sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: every edge that has a pending expectation gets its EX outputs compared.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check({mon_e.nm, "_exv"}, 32'(hif.ex_valid), 32'(mon_e.v));
            check({mon_e.nm, "_sel"}, 32'(hif.ex_fwd_sel), 32'(mon_e.sel));
        end
    end

    task automatic drive(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] rd, input logic wr, input logic ld,
                         input logic fl, input logic hd);
        hif.id_valid    = v;
        hif.id_rs_addr  = {r1, r0};
        hif.id_rd_addr  = rd;
        hif.id_rd_write = wr;
        hif.id_is_load  = ld;
        hif.flush       = fl;
        hif.hold        = hd;
    endtask

    task automatic step(input string nm, input logic v, input logic [4:0] r0,
                        input logic [4:0] r1, input logic [4:0] rd, input logic wr,
                        input logic ld, input logic fl, input logic hd,
                        input logic exp_st, input logic exp_v, input logic [3:0] exp_sel);
        exp_t e;
        @(negedge clock);
        drive(v, r0, r1, rd, wr, ld, fl, hd);
        #1;
        check({nm, "_stall"}, 32'(hif.stall), 32'(exp_st));
        e.nm  = nm;
        e.v   = exp_v;
        e.sel = exp_sel;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        check("rst_stall", 32'(hif.stall), 0);
        check("rst_exv",   32'(hif.ex_valid), 0);
        check("rst_sel",   32'(hif.ex_fwd_sel), 0);
        reset = 1'b0;

        // ALU producer rd=5, then consumers at MEM, WB and beyond.
        step("alu_prod", 1, 0, 0, 5, 1, 0, 0, 0,  0, 1, 4'h0);
        step("dep_mem",  1, 5, 0, 0, 0, 0, 0, 0,  0, 1, 4'h2);
        step("dep_wb",   1, 0, 5, 0, 0, 0, 0, 0,  0, 1, 4'hC);
        step("dep_gone", 1, 5, 0, 0, 0, 0, 0, 0,  0, 1, 4'h0);

        // Load rd=7 then rs2=7: one stall bubble, then sel=3 on port 1.
        step("ld_prod",  1, 0, 0, 7, 1, 1, 0, 0,  0, 1, 4'h0);
        step("lu_stall", 1, 0, 7, 0, 0, 0, 0, 0,  1, 0, 4'h0);
        step("lu_go",    1, 0, 7, 0, 0, 0, 0, 0,  0, 1, 4'hC);
        step("nop1",     1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 4'h0);

        // x0 destination and non-writing producers never match.
        step("x0_prod",  1, 0, 0, 0, 1, 1, 0, 0,  0, 1, 4'h0);
        step("x0_use",   1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 4'h0);
        step("nw_prod",  1, 0, 0, 4, 0, 1, 0, 0,  0, 1, 4'h0);
        step("nw_use",   1, 4, 4, 0, 0, 0, 0, 0,  0, 1, 4'h0);

        // Two producers of rd=3: the younger one (EX) wins.
        step("y_old",    1, 0, 0, 3, 1, 0, 0, 0,  0, 1, 4'h0);
        step("y_new",    1, 0, 0, 3, 1, 0, 0, 0,  0, 1, 4'h0);
        step("y_use",    1, 3, 0, 0, 0, 0, 0, 0,  0, 1, 4'h2);

        // Flush during the hazard cycle: no stall, bubble, and rd=11 never recorded.
        step("fl_ld",    1, 0, 0, 9, 1, 1, 0, 0,  0, 1, 4'h0);
        step("fl_kill",  1, 9, 0, 11, 1, 0, 1, 0, 0, 0, 4'h0);
        step("fl_after", 1, 9, 11, 0, 0, 0, 0, 0, 0, 1, 4'h3);
        step("nop2",     1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 4'h0);

        // Hold for three cycles during a load-use hazard: stall persists, EX frozen.
        step("h_ld",     1, 0, 0, 7, 1, 1, 0, 0,  0, 1, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step("h_hold", 1, 7, 0, 0, 0, 0, 0, 1, 1, 1, 4'h0);
        end
        step("h_stall",  1, 7, 0, 0, 0, 0, 0, 0,  1, 0, 4'h0);
        step("h_go",     1, 7, 0, 0, 0, 0, 0, 0,  0, 1, 4'h3);

        // Asynchronous reset between edges clears the hazard and EX state at once.
        step("r_ld",     1, 0, 0, 7, 1, 1, 0, 0,  0, 1, 4'h0);
        @(negedge clock);
        drive(1, 7, 0, 0, 0, 0, 0, 0);
        #1;
        check("r_pre_stall", 32'(hif.stall), 1);
        check("r_pre_exv",   32'(hif.ex_valid), 1);
        #1 reset = 1'b1;
        #1;
        check("r_stall", 32'(hif.stall), 0);
        check("r_exv",   32'(hif.ex_valid), 0);
        check("r_sel",   32'(hif.ex_fwd_sel), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        step("r_after",  1, 7, 0, 0, 0, 0, 0, 0,  0, 1, 4'h0);

        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clock);
        check("sb_drain", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
